// File: rtl/ssqa_ctrl_pkg.sv
// Shared state encoding and zero-means-one configuration constants for the
// annealing controller and its Q ramp.
package ssqa_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_NEXT    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // A zero in any of these fields is run as this value instead.
    localparam int unsigned TAU_MIN    = 1;
    localparam int unsigned QSTEP_MIN  = 1;
    localparam int unsigned NTRIAL_MIN = 1;

endpackage

// File: rtl/anneal_ctrl_if.sv
// Signal bundle between the annealing controller (slave) and the host /
// spin scheduler side (master).
interface anneal_ctrl_if #(
    parameter int TEM_WIDTH   = 8,
    parameter int TRIAL_WIDTH = 8
);
    logic                          start;
    logic [7:0]                    tau;
    logic signed [TEM_WIDTH-1:0]   Q0;
    logic [TEM_WIDTH-1:0]          Qstep;
    logic signed [TEM_WIDTH-1:0]   Qmax;
    logic [TRIAL_WIDTH-1:0]        n_trials;
    logic                          iter_done;
    logic                          trial_fin;

    logic                          comp_en;
    logic signed [TEM_WIDTH-1:0]   Q;
    logic [7:0]                    count_comp;
    logic [TRIAL_WIDTH-1:0]        trial_idx;
    logic                          snap_req;
    logic                          busy;
    logic                          done;

    modport master (
        output start, tau, Q0, Qstep, Qmax, n_trials, iter_done, trial_fin,
        input  comp_en, Q, count_comp, trial_idx, snap_req, busy, done
    );

    modport slave (
        input  start, tau, Q0, Qstep, Qmax, n_trials, iter_done, trial_fin,
        output comp_en, Q, count_comp, trial_idx, snap_req, busy, done
    );
endinterface

// File: rtl/q_ramp.sv
// Q ramp: counts iterations within a Q step and raises Q by Qstep every tau
// iterations, saturating at Qmax.
module q_ramp
    import ssqa_ctrl_pkg::*;
#(
    parameter int TEM_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_sys,
    input  logic                        load,
    input  logic                        step,
    input  logic [7:0]                  tau,
    input  logic [TEM_WIDTH-1:0]        Qstep,
    input  logic signed [TEM_WIDTH-1:0] Qmax,
    input  logic signed [TEM_WIDTH-1:0] Q0,
    output logic signed [TEM_WIDTH-1:0] Q,
    output logic [7:0]                  count_comp
);
    // Two guard bits: the largest Q plus the largest unsigned Qstep does not
    // fit in one extra signed bit.
    localparam int SW = TEM_WIDTH + 2;

    logic [7:0]                  tau_last;
    logic [TEM_WIDTH-1:0]        qstep_eff;
    logic signed [SW-1:0]        q_ext;
    logic signed [SW-1:0]        step_ext;
    logic signed [SW-1:0]        qmax_ext;
    logic signed [SW-1:0]        q_sum;
    logic signed [TEM_WIDTH-1:0] q_next;

    // NOTE: combinational logic uses blocking '=' and assigns every output on every path, so no latch is inferred.
    always_comb begin
        tau_last  = ((tau == '0) ? 8'(TAU_MIN) : tau) - 8'd1;
        qstep_eff = (Qstep == '0) ? TEM_WIDTH'(QSTEP_MIN) : Qstep;
        q_ext     = {{2{Q[TEM_WIDTH-1]}}, Q};
        step_ext  = {2'b00, qstep_eff};
        qmax_ext  = {{2{Qmax[TEM_WIDTH-1]}}, Qmax};
        q_sum     = q_ext + step_ext;
        q_next    = (q_sum > qmax_ext) ? Qmax : q_sum[TEM_WIDTH-1:0];
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_sys) begin
        if (!rst_sys) begin
            Q          <= '0;
            count_comp <= '0;
        end else if (load) begin
            Q          <= Q0;
            count_comp <= '0;
        end else if (step) begin
            if (count_comp == tau_last) begin
                count_comp <= '0;
                Q          <= q_next;
            end else begin
                count_comp <= count_comp + 8'd1;
            end
        end
    end

endmodule

// File: rtl/anneal_ctrl.sv
// Annealing run controller: launches n_trials trials, ramps Q while each runs,
// and requests a spin-state snapshot at the end of every trial.
module anneal_ctrl
    import ssqa_ctrl_pkg::*;
#(
    parameter int TEM_WIDTH   = 8,
    parameter int TRIAL_WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_sys,
    anneal_ctrl_if.slave  bus
);
    state_t                      state;
    logic [7:0]                  tau_r;
    logic signed [TEM_WIDTH-1:0] q0_r;
    logic [TEM_WIDTH-1:0]        qstep_r;
    logic signed [TEM_WIDTH-1:0] qmax_r;
    logic [TRIAL_WIDTH-1:0]      n_trials_r;
    logic [TRIAL_WIDTH-1:0]      trial_idx;
    logic [TRIAL_WIDTH-1:0]      trial_last;

    logic                        accept;
    logic                        last_trial;
    logic                        load;
    logic                        step;
    logic signed [TEM_WIDTH-1:0] q0_sel;
    logic signed [TEM_WIDTH-1:0] q;
    logic [7:0]                  count_comp;

    assign accept     = (state == ST_IDLE) && bus.start;
    assign trial_last = ((n_trials_r == '0) ? TRIAL_WIDTH'(NTRIAL_MIN) : n_trials_r)
                        - TRIAL_WIDTH'(1);
    assign last_trial = (trial_idx == trial_last);

    // Q is reloaded on every entry to LAUNCH; from IDLE the config is being
    // latched on that same edge, so take Q0 straight from the port.
    assign load   = accept || ((state == ST_NEXT) && !last_trial);
    assign q0_sel = accept ? bus.Q0 : q0_r;
    assign step   = (state == ST_RUN) && bus.iter_done;

    q_ramp #(.TEM_WIDTH(TEM_WIDTH)) u_ramp (
        .clk        (clk),
        .rst_sys    (rst_sys),
        .load       (load),
        .step       (step),
        .tau        (tau_r),
        .Qstep      (qstep_r),
        .Qmax       (qmax_r),
        .Q0         (q0_sel),
        .Q          (q),
        .count_comp (count_comp)
    );

    always_ff @(posedge clk or negedge rst_sys) begin
        if (!rst_sys) begin
            state      <= ST_IDLE;
            tau_r      <= '0;
            q0_r       <= '0;
            qstep_r    <= '0;
            qmax_r     <= '0;
            n_trials_r <= '0;
            trial_idx  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        tau_r      <= bus.tau;
                        q0_r       <= bus.Q0;
                        qstep_r    <= bus.Qstep;
                        qmax_r     <= bus.Qmax;
                        n_trials_r <= bus.n_trials;
                        trial_idx  <= '0;
                        state      <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH:  state <= ST_RUN;
                ST_RUN:     if (bus.trial_fin) state <= ST_CAPTURE;
                ST_CAPTURE: state <= ST_NEXT;
                ST_NEXT: begin
                    if (last_trial) begin
                        state <= ST_DONE;
                    end else begin
                        trial_idx <= trial_idx + TRIAL_WIDTH'(1);
                        state     <= ST_LAUNCH;
                    end
                end
                ST_DONE:    state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    assign bus.comp_en    = (state == ST_LAUNCH);
    assign bus.snap_req   = (state == ST_CAPTURE);
    assign bus.done       = (state == ST_DONE);
    assign bus.busy       = (state != ST_IDLE);
    assign bus.Q          = q;
    assign bus.count_comp = count_comp;
    assign bus.trial_idx  = trial_idx;

endmodule
